// File: rtl/trainerror_sb_arbiter.sv
// Round-robin arbiter sharing one sideband serializer between the local entry-request
// source (requester 0) and the entry-response source (requester 1) during trainerror.
//
// state          | meaning
// ---------------+--------------------------------------------------------------
// S_IDLE         | waiting for enable and a pending valid; arbitrates and latches
// S_ISSUE        | one-cycle issue strobe to the serializer
// S_WAIT_BUSY_HI | waiting for serializer busy to rise, bounded by BUSY_TIMEOUT
// S_WAIT_BUSY_LO | waiting for busy to fall, then pulses the granted done output
// S_GAP          | one dead cycle so the served requester can retire its valid
module trainerror_sb_arbiter #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_req_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_req_msg,
  input  logic                    i_resp_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_resp_msg,
  input  logic                    i_sb_busy,
  output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
  output logic                    o_sb_valid,
  output logic                    o_req_falling_edge_busy,
  output logic                    o_resp_falling_edge_busy,
  output logic                    o_timeout
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_ISSUE        = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY_HI = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY_LO = 3'd3;
  localparam logic [2:0] S_GAP          = 3'd4;

  logic [2:0]              state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    grant_q, grant_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q;
  logic                    grant_sel;
  logic                    done_req_d, done_resp_d, timeout_d;
  logic                    sb_valid_d;
  logic [SB_MSG_WIDTH-1:0] sb_msg_d;
  logic                    sb_valid_q, done_req_q, done_resp_q, timeout_q;
  logic [SB_MSG_WIDTH-1:0] sb_msg_q;

  // On contention the requester not served last wins; a lone valid always wins.
  assign grant_sel = (i_req_valid && i_resp_valid) ? ~ptr_q : i_resp_valid;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    msg_d       = msg_q;
    cnt_d       = cnt_q;
    done_req_d  = 1'b0;
    done_resp_d = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable && (i_req_valid || i_resp_valid)) begin
          grant_d = grant_sel;
          msg_d   = grant_sel ? i_resp_msg : i_req_msg;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY_HI;
      end
      S_WAIT_BUSY_HI: begin
        if (i_sb_busy) begin
          state_d = S_WAIT_BUSY_LO;
        end else if (cnt_q >= CNT_LAST) begin
          cnt_d     = CNT_MAX;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_BUSY_LO: begin
        if (busy_q && !i_sb_busy) begin
          done_req_d  = ~grant_q;
          done_resp_d = grant_q;
          ptr_d       = grant_q;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort keeps the pointer and holding register as they were.
    if (!i_enable && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      msg_d       = msg_q;
      cnt_d       = cnt_q;
      done_req_d  = 1'b0;
      done_resp_d = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  assign sb_valid_d = (state_d == S_ISSUE);
  assign sb_msg_d   = ((state_d == S_ISSUE) || (state_d == S_WAIT_BUSY_HI) ||
                       (state_d == S_WAIT_BUSY_LO)) ? msg_d : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      grant_q     <= 1'b0;
      msg_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      sb_valid_q  <= 1'b0;
      sb_msg_q    <= '0;
      done_req_q  <= 1'b0;
      done_resp_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      msg_q       <= msg_d;
      cnt_q       <= cnt_d;
      busy_q      <= i_sb_busy;
      sb_valid_q  <= sb_valid_d;
      sb_msg_q    <= sb_msg_d;
      done_req_q  <= done_req_d;
      done_resp_q <= done_resp_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_sb_msg                 = sb_msg_q;
  assign o_sb_valid               = sb_valid_q;
  assign o_req_falling_edge_busy  = done_req_q;
  assign o_resp_falling_edge_busy = done_resp_q;
  assign o_timeout                = timeout_q;

endmodule

// File: tb/tb_trainerror_sb_arbiter.sv
// Directed bench for trainerror_sb_arbiter: single request, contention, pointer,
// timeout, abort, gap and reset sequences with hand-computed per-cycle outputs.
module tb_trainerror_sb_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       req_valid;
  logic [3:0] req_msg;
  logic       resp_valid;
  logic [3:0] resp_msg;
  logic       sb_busy;
  logic [3:0] sb_msg;
  logic       sb_valid;
  logic       done_req;
  logic       done_resp;
  logic       timeout;

  int    n_chk  = 0;
  int    n_fail = 0;
  string phase  = "init";

  trainerror_sb_arbiter #(.SB_MSG_WIDTH(4), .BUSY_TIMEOUT(16)) dut (
    .i_clk                    (clk),
    .i_rst                    (rst),
    .i_enable                 (enable),
    .i_req_valid              (req_valid),
    .i_req_msg                (req_msg),
    .i_resp_valid             (resp_valid),
    .i_resp_msg               (resp_msg),
    .i_sb_busy                (sb_busy),
    .o_sb_msg                 (sb_msg),
    .o_sb_valid               (sb_valid),
    .o_req_falling_edge_busy  (done_req),
    .o_resp_falling_edge_busy (done_resp),
    .o_timeout                (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic expo(input logic v, input logic [3:0] m, input logic dq,
                      input logic dr, input logic t);
    chk("sb_valid", 32'(sb_valid), 32'(v));
    chk("sb_msg", 32'(sb_msg), 32'(m));
    chk("done_req", 32'(done_req), 32'(dq));
    chk("done_resp", 32'(done_resp), 32'(dr));
    chk("timeout", 32'(timeout), 32'(t));
  endtask

  // Valids are set in an IDLE cycle; busy is high for exactly one sampled edge.
  // The served requester keeps valid through its done cycle and drops it after.
  task automatic handshake(input logic [3:0] m, input logic who);
    step(); expo(1'b1, m, 1'b0, 1'b0, 1'b0);
    step(); expo(1'b0, m, 1'b0, 1'b0, 1'b0);
    sb_busy = 1'b1;
    step(); expo(1'b0, m, 1'b0, 1'b0, 1'b0);
    sb_busy = 1'b0;
    step(); expo(1'b0, 4'h0, ~who, who, 1'b0);
    step();
    if (who) resp_valid = 1'b0; else req_valid = 1'b0;
    expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req_valid = 1'b0; req_msg = 4'h0;
    resp_valid = 1'b0; resp_msg = 4'h0; sb_busy = 1'b0;
    phase = "reset";
    step(); step();
    expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single request; valid dropped right after grant must not cancel it.
    phase = "single";
    enable = 1'b1; req_valid = 1'b1; req_msg = 4'hF;
    step(); expo(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b0;
    step(); expo(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    step(); expo(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    sb_busy = 1'b1;
    step(); expo(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    step(); expo(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    step(); sb_busy = 1'b0; expo(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    step(); expo(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Contention from reset: requester 1 first, then requester 0.
    phase = "contend";
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 1'b1; req_msg = 4'hF; resp_valid = 1'b1; resp_msg = 4'hE;
    handshake(4'hE, 1'b1);
    handshake(4'hF, 1'b0);
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // After requester 1 is served, contention goes to requester 0.
    phase = "pointer";
    resp_valid = 1'b1; resp_msg = 4'hE;
    handshake(4'hE, 1'b1);
    req_valid = 1'b1; req_msg = 4'hF; resp_valid = 1'b1; resp_msg = 4'hE;
    handshake(4'hF, 1'b0);
    handshake(4'hE, 1'b1);

    // Timeout: busy never rises; pointer stays at requester 1.
    phase = "timeout";
    req_valid = 1'b1; req_msg = 4'hA;
    step(); expo(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b0;
    step(); expo(1'b0, 4'hA, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i <= 17; i++) begin
      step(); expo(1'b0, 4'hA, 1'b0, 1'b0, 1'b0);
    end
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1; req_msg = 4'hF; resp_valid = 1'b1; resp_msg = 4'hE;
    handshake(4'hF, 1'b0);
    handshake(4'hE, 1'b1);

    // Abort during WAIT_BUSY_LOW; a later busy fall is ignored.
    phase = "abort";
    req_valid = 1'b1; req_msg = 4'h5;
    step(); expo(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b0;
    step(); expo(1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    sb_busy = 1'b1;
    step(); expo(1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    sb_busy = 1'b0;
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Requester 0 keeps valid into the gap cycle; no second issue.
    phase = "gap";
    req_valid = 1'b1; req_msg = 4'h3;
    handshake(4'h3, 1'b0);
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Reset during ISSUE clears outputs and the pointer.
    phase = "rst_issue";
    resp_valid = 1'b1; resp_msg = 4'hE;
    handshake(4'hE, 1'b1);
    req_valid = 1'b1; req_msg = 4'h9;
    step(); expo(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; req_valid = 1'b0;
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); expo(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1; req_msg = 4'hF; resp_valid = 1'b1; resp_msg = 4'hE;
    handshake(4'hE, 1'b1);
    handshake(4'hF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
